// File: rtl/dcache_nxt_lv_line_xfer.sv
// Cache-line transfer engine: splits one line fill or writeback into single-word ICB
// commands at ascending addresses, collects the responses and returns the whole line.
module dcache_nxt_lv_line_xfer #(
  parameter int unsigned CACHE_LINE_WORD_N = 8,
  parameter int          SIM_DELAY         = 1
) (
  input  logic                            aclk,
  input  logic                            aresetn,

  input  logic [31:0]                     req_addr,
  input  logic                            req_wen,
  input  logic [CACHE_LINE_WORD_N*32-1:0] req_wdata,
  input  logic                            req_valid,
  output logic                            req_ready,

  output logic [CACHE_LINE_WORD_N*32-1:0] cpl_rdata,
  output logic                            cpl_err,
  output logic                            cpl_wen,
  output logic                            cpl_valid,
  input  logic                            cpl_ready,

  output logic [31:0]                     m_icb_cmd_addr,
  output logic                            m_icb_cmd_read,
  output logic [31:0]                     m_icb_cmd_wdata,
  output logic [3:0]                      m_icb_cmd_wmask,
  output logic                            m_icb_cmd_valid,
  input  logic                            m_icb_cmd_ready,

  input  logic [31:0]                     m_icb_rsp_rdata,
  input  logic                            m_icb_rsp_err,
  input  logic                            m_icb_rsp_valid,
  output logic                            m_icb_rsp_ready
);

  localparam int unsigned N     = CACHE_LINE_WORD_N;
  localparam int unsigned LW    = $clog2(N);
  localparam int unsigned CW    = LW + 1;
  localparam int unsigned LineW = N * 32;

  // Clears the word-offset and byte-offset bits of the request address.
  localparam logic [31:0] BaseMask = ~((32'd1 << (LW + 2)) - 32'd1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StCpl  = 2'd2;

  if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16) || SIM_DELAY < 0) begin : g_bad_param
    $error("dcache_nxt_lv_line_xfer: unsupported parameter value");
  end

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    cmd_cnt_q, cmd_cnt_d;
  logic [CW-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic             err_q,     err_d;
  logic             wen_q,     wen_d;
  logic [31:0]      base_q,    base_d;
  logic [LineW-1:0] wdata_q,   wdata_d;
  logic [LineW-1:0] rdata_q,   rdata_d;

  logic             cmd_active;
  logic             cmd_hs;
  logic             rsp_hs;
  logic [31:0]      cmd_word;

  assign cmd_active = (state_q == StBusy) && (cmd_cnt_q < CW'(N));
  assign cmd_hs     = cmd_active && m_icb_cmd_ready;
  assign rsp_hs     = (state_q == StBusy) && m_icb_rsp_valid;

  always_comb begin
    cmd_word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cmd_cnt_q == CW'(k)) begin
        cmd_word = wdata_q[32*k +: 32];
      end
    end
  end

  // Command fields are gated by cmd_active so they read as zero outside a command.
  always_comb begin
    req_ready       = (state_q == StIdle);
    cpl_valid       = (state_q == StCpl);
    cpl_rdata       = rdata_q;
    cpl_err         = err_q;
    cpl_wen         = wen_q;
    m_icb_cmd_valid = cmd_active;
    m_icb_cmd_addr  = cmd_active ? (base_q + {{(32-CW-2){1'b0}}, cmd_cnt_q, 2'b00}) : 32'h0;
    m_icb_cmd_read  = cmd_active && !wen_q;
    m_icb_cmd_wmask = (cmd_active && wen_q) ? 4'hF : 4'h0;
    m_icb_cmd_wdata = cmd_active ? cmd_word : 32'h0;
    m_icb_rsp_ready = (state_q == StBusy);
  end

  always_comb begin
    state_d   = state_q;
    cmd_cnt_d = cmd_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    err_d     = err_q;
    wen_d     = wen_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d   = StBusy;
          base_d    = req_addr & BaseMask;
          wen_d     = req_wen;
          wdata_d   = req_wdata;
          cmd_cnt_d = '0;
          rsp_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      StBusy: begin
        if (cmd_hs) begin
          cmd_cnt_d = cmd_cnt_q + CW'(1);
        end
        // Responses are consumed independently of the command side.
        if (rsp_hs) begin
          if (!wen_q) begin
            for (int unsigned k = 0; k < N; k++) begin
              if (rsp_cnt_q == CW'(k)) begin
                rdata_d[32*k +: 32] = m_icb_rsp_rdata;
              end
            end
          end
          err_d     = err_q | m_icb_rsp_err;
          rsp_cnt_d = rsp_cnt_q + CW'(1);
          if (rsp_cnt_q == CW'(N - 1)) begin
            state_d = StCpl;
          end
        end
      end
      StCpl: begin
        if (cpl_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      cmd_cnt_q <= '0;
      rsp_cnt_q <= '0;
      err_q     <= 1'b0;
      wen_q     <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cmd_cnt_q <= cmd_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      err_q     <= err_d;
      wen_q     <= wen_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dcache_nxt_lv_line_xfer.sv
// Bench for dcache_nxt_lv_line_xfer: line-level model plus scoreboard on an N=8 instance,
// and hand-timed checks on an N=1 instance.
module tb_dcache_nxt_lv_line_xfer;

  localparam int N  = 8;
  localparam int LW = N * 32;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0]   req_addr;
  logic          req_wen;
  logic [LW-1:0] req_wdata;
  logic          req_valid, req_ready;
  logic [LW-1:0] cpl_rdata;
  logic          cpl_err, cpl_wen, cpl_valid, cpl_ready;
  logic [31:0]   cmd_addr, cmd_wdata;
  logic          cmd_read, cmd_valid, cmd_ready;
  logic [3:0]    cmd_wmask;
  logic [31:0]   rsp_rdata;
  logic          rsp_err, rsp_valid, rsp_ready;

  logic [31:0] r1_addr;
  logic        r1_valid, r1_ready;
  logic [31:0] c1_rdata;
  logic        c1_err, c1_wen, c1_valid;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_read, m1_valid;
  logic [3:0]  m1_wmask;
  logic [31:0] s1_rdata;
  logic        s1_valid, s1_rsp_ready;

  dcache_nxt_lv_line_xfer #(.CACHE_LINE_WORD_N(N), .SIM_DELAY(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
    .req_valid(req_valid), .req_ready(req_ready),
    .cpl_rdata(cpl_rdata), .cpl_err(cpl_err), .cpl_wen(cpl_wen),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .m_icb_cmd_addr(cmd_addr), .m_icb_cmd_read(cmd_read), .m_icb_cmd_wdata(cmd_wdata),
    .m_icb_cmd_wmask(cmd_wmask), .m_icb_cmd_valid(cmd_valid), .m_icb_cmd_ready(cmd_ready),
    .m_icb_rsp_rdata(rsp_rdata), .m_icb_rsp_err(rsp_err),
    .m_icb_rsp_valid(rsp_valid), .m_icb_rsp_ready(rsp_ready)
  );

  dcache_nxt_lv_line_xfer #(.CACHE_LINE_WORD_N(1), .SIM_DELAY(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .req_addr(r1_addr), .req_wen(1'b0), .req_wdata(32'h0),
    .req_valid(r1_valid), .req_ready(r1_ready),
    .cpl_rdata(c1_rdata), .cpl_err(c1_err), .cpl_wen(c1_wen),
    .cpl_valid(c1_valid), .cpl_ready(1'b1),
    .m_icb_cmd_addr(m1_addr), .m_icb_cmd_read(m1_read), .m_icb_cmd_wdata(m1_wdata),
    .m_icb_cmd_wmask(m1_wmask), .m_icb_cmd_valid(m1_valid), .m_icb_cmd_ready(1'b1),
    .m_icb_rsp_rdata(s1_rdata), .m_icb_rsp_err(1'b0),
    .m_icb_rsp_valid(s1_valid), .m_icb_rsp_ready(s1_rsp_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        read;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  // Line-level model: expected command list, slave response queue, assembled line.
  cmd_t          exp_cmds[$];
  rsp_t          slv_q[$];
  logic [31:0]   cmd_log[$];
  logic [31:0]   wdata_log[$];
  logic [31:0]   model_line[N];
  logic [LW-1:0] exp_line;
  cmd_t          cur_cmd;
  rsp_t          cur_rsp;
  logic [31:0]   base_tmp;
  bit            model_busy = 0;
  bit            model_wen  = 0;
  bit            model_err  = 0;
  int            rsp_seen   = 0;
  int            cmd_hs_n   = 0;
  int            cyc        = 0;
  int            req_cyc    = 0;
  int            first_cmd_cyc = -1;
  int            cpl_cyc    = -1;
  logic [LW-1:0] last_rdata = '0;
  logic          last_err   = 1'b0;
  logic          last_wen   = 1'b0;

  bit          stall_mode = 0;
  logic [31:0] rbase      = '0;
  int          err_idx    = -1;
  bit          s1_pend    = 0;

  function automatic logic [31:0] log_at(input bit wd, input int i);
    if (wd) return (i < wdata_log.size()) ? wdata_log[i] : 32'hxxxx_xxxx;
    return (i < cmd_log.size()) ? cmd_log[i] : 32'hxxxx_xxxx;
  endfunction

  always @(posedge aclk) cyc = cyc + 1;

  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_cmds.delete();
      slv_q.delete();
      model_busy = 0;
      model_wen  = 0;
      model_err  = 0;
      rsp_seen   = 0;
      cmd_hs_n   = 0;
      s1_pend    = 0;
      for (int k = 0; k < N; k++) model_line[k] = '0;
    end else begin
      for (int k = 0; k < N; k++) exp_line[32*k +: 32] = model_line[k];
      check("req_ready", req_ready, !model_busy);
      check("cmd_valid", cmd_valid, exp_cmds.size() > 0);
      if (cmd_valid && exp_cmds.size() > 0) begin
        check("cmd_addr", cmd_addr, exp_cmds[0].addr);
        check("cmd_read", cmd_read, exp_cmds[0].read);
        check("cmd_wmask", cmd_wmask, exp_cmds[0].mask);
        check("cmd_wdata", cmd_wdata, exp_cmds[0].wdata);
      end
      check("rsp_ready", rsp_ready, model_busy && rsp_seen < N);
      check("cpl_valid", cpl_valid, model_busy && rsp_seen == N);
      if (cpl_valid) begin
        check("cpl_rdata", cpl_rdata, exp_line);
        check("cpl_err", cpl_err, model_err);
        check("cpl_wen", cpl_wen, model_wen);
      end
      if (cmd_valid && first_cmd_cyc < 0) first_cmd_cyc = cyc;
      if (cpl_valid && cpl_cyc < 0) cpl_cyc = cyc;

      // Handshakes that complete at the coming rising edge.
      if (rsp_valid && rsp_ready && slv_q.size() > 0) begin
        cur_rsp = slv_q.pop_front();
        if (!model_wen) model_line[rsp_seen] = cur_rsp.data;
        model_err = model_err | cur_rsp.err;
        rsp_seen++;
      end
      if (cmd_valid && cmd_ready && exp_cmds.size() > 0) begin
        exp_cmds.delete(0);
        cur_rsp.data = rbase + 32'(cmd_hs_n);
        cur_rsp.err  = (cmd_hs_n == err_idx);
        slv_q.push_back(cur_rsp);
        cmd_log.push_back(cmd_addr);
        wdata_log.push_back(cmd_wdata);
        cmd_hs_n++;
      end
      if (cpl_valid && cpl_ready) begin
        model_busy = 0;
        last_rdata = cpl_rdata;
        last_err   = cpl_err;
        last_wen   = cpl_wen;
      end
      if (req_valid && req_ready) begin
        model_busy    = 1;
        model_wen     = req_wen;
        model_err     = 0;
        rsp_seen      = 0;
        cmd_hs_n      = 0;
        req_cyc       = cyc;
        first_cmd_cyc = -1;
        cpl_cyc       = -1;
        cmd_log.delete();
        wdata_log.delete();
        base_tmp = (req_addr / (4 * N)) * (4 * N);
        for (int k = 0; k < N; k++) begin
          cur_cmd.addr  = base_tmp + 32'(4 * k);
          cur_cmd.read  = !req_wen;
          cur_cmd.mask  = req_wen ? 4'hF : 4'h0;
          cur_cmd.wdata = req_wdata[32*k +: 32];
          exp_cmds.push_back(cur_cmd);
        end
      end
      s1_pend = m1_valid;
    end
  end

  // Slave: one response per accepted command, in order, starting the cycle after.
  always @(posedge aclk) begin
    #1;
    cmd_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (slv_q.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_rdata = slv_q[0].data;
      rsp_err   = slv_q[0].err;
    end else begin
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
    end
    s1_valid = s1_pend;
    s1_rdata = s1_pend ? 32'h5A5A_0001 : 32'h0;
  end

  task automatic start_req(input logic [31:0] a, input logic w, input logic [LW-1:0] d);
    @(posedge aclk); #1;
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    req_valid = 1'b1;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    req_wdata = ~d;
    req_addr  = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (model_busy && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    if (model_busy) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: still busy after %0d cycles, expected completion", budget);
    end
  endtask

  logic [LW-1:0] line;

  initial begin
    req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_valid = 1'b0; cpl_ready = 1'b1;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    r1_addr = '0; r1_valid = 1'b0; s1_valid = 1'b0; s1_rdata = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_rsp_ready", rsp_ready, 1'b0);
    check("rst_cpl_valid", cpl_valid, 1'b0);
    check("rst_cpl_rdata", cpl_rdata, '0);
    aresetn = 1'b1;

    // Fill at 0x1234, best-case slave.
    for (int k = 0; k < N; k++) line[32*k +: 32] = $urandom;
    rbase = 32'hA000_0000;
    start_req(32'h0000_1234, 1'b0, line);
    wait_done(100);
    check("t1_first_cmd_cyc", 32'(first_cmd_cyc - req_cyc), 32'd1);
    check("t1_cpl_cyc", 32'(cpl_cyc - req_cyc), 32'd10);
    check("t1_addr0", log_at(0, 0), 32'h0000_1220);
    check("t1_addr7", log_at(0, 7), 32'h0000_123C);
    for (int k = 0; k < N; k++) check("t1_word", last_rdata[32*k +: 32], 32'hA000_0000 + 32'(k));
    check("t1_err", last_err, 1'b0);

    // Writeback at 0x8000_0040.
    for (int k = 0; k < N; k++) line[32*k +: 32] = 32'h1111_1111 * 32'(k);
    rbase = 32'hDEAD_0000;
    start_req(32'h8000_0040, 1'b1, line);
    wait_done(100);
    check("t2_addr0", log_at(0, 0), 32'h8000_0040);
    check("t2_addr7", log_at(0, 7), 32'h8000_005C);
    check("t2_wdata3", log_at(1, 3), 32'h3333_3333);
    check("t2_wdata7", log_at(1, 7), 32'h7777_7777);
    check("t2_wen", last_wen, 1'b1);
    check("t2_err", last_err, 1'b0);
    check("t2_line_kept", last_rdata[31:0], 32'hA000_0000);

    // Fill with command stalls and an error on response 5.
    stall_mode = 1;
    err_idx    = 5;
    rbase      = 32'hC0DE_0000;
    for (int k = 0; k < N; k++) line[32*k +: 32] = $urandom;
    start_req(32'h0000_4568, 1'b0, line);
    wait_done(300);
    stall_mode = 0;
    err_idx    = -1;
    check("t3_ncmds", 32'(cmd_log.size()), 32'd8);
    check("t3_addr0", log_at(0, 0), 32'h0000_4560);
    check("t3_err", last_err, 1'b1);
    check("t3_word7", last_rdata[255:224], 32'hC0DE_0007);

    // Completion held off for 20 cycles.
    cpl_ready = 1'b0;
    rbase     = 32'h7000_0000;
    start_req(32'h0000_0300, 1'b0, line);
    for (int n = 0; n < 100 && !(model_busy && rsp_seen == N); n++) begin
      @(posedge aclk); #1;
    end
    repeat (20) begin
      @(posedge aclk); #1;
    end
    cpl_ready = 1'b1;
    wait_done(50);
    check("t4_ncmds", 32'(cmd_log.size()), 32'd8);
    check("t4_word3", last_rdata[127:96], 32'h7000_0003);

    // Reset pulsed after the third command handshake.
    rbase = 32'hB000_0000;
    start_req(32'h0000_5000, 1'b0, line);
    for (int n = 0; n < 50 && cmd_hs_n < 3; n++) begin
      @(posedge aclk); #1;
    end
    check("t5_hs_before_rst", 32'(cmd_hs_n), 32'd3);
    aresetn = 1'b0;
    #1;
    check("t5_req_ready", req_ready, 1'b1);
    check("t5_cmd_valid", cmd_valid, 1'b0);
    check("t5_rsp_ready", rsp_ready, 1'b0);
    check("t5_cpl_valid", cpl_valid, 1'b0);
    check("t5_cpl_err", cpl_err, 1'b0);
    check("t5_cpl_wen", cpl_wen, 1'b0);
    check("t5_cpl_rdata", cpl_rdata, '0);
    check("t5_cmd_fields", {cmd_addr, cmd_wdata, cmd_wmask, cmd_read}, '0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rbase = 32'h2000_0000;
    start_req(32'h0000_2000, 1'b0, line);
    wait_done(100);
    check("t5b_addr0", log_at(0, 0), 32'h0000_2000);
    check("t5b_cpl_cyc", 32'(cpl_cyc - req_cyc), 32'd10);
    check("t5b_word0", last_rdata[31:0], 32'h2000_0000);

    // N=1 instance: fill at 0x7.
    @(posedge aclk); #1;
    r1_addr  = 32'h0000_0007;
    r1_valid = 1'b1;
    @(negedge aclk);
    check("n1_req_ready", r1_ready, 1'b1);
    @(posedge aclk); #1;
    r1_valid = 1'b0;
    @(negedge aclk);
    check("n1_cmd_valid", m1_valid, 1'b1);
    check("n1_cmd_addr", m1_addr, 32'h0000_0004);
    check("n1_cmd_read", m1_read, 1'b1);
    check("n1_cmd_wmask", m1_wmask, 4'h0);
    check("n1_cmd_wdata", m1_wdata, 32'h0);
    @(negedge aclk);
    check("n1_cmd_done", m1_valid, 1'b0);
    check("n1_rsp_ready", s1_rsp_ready, 1'b1);
    check("n1_cpl_early", c1_valid, 1'b0);
    @(negedge aclk);
    check("n1_cpl_valid", c1_valid, 1'b1);
    check("n1_cpl_rdata", c1_rdata, 32'h5A5A_0001);
    check("n1_cpl_err", c1_err, 1'b0);
    check("n1_cpl_wen", c1_wen, 1'b0);
    @(negedge aclk);
    check("n1_cpl_taken", c1_valid, 1'b0);
    check("n1_req_ready_back", r1_ready, 1'b1);

    repeat (2) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
